// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helper for the sequential signed multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_signed_if.sv
// Start/done handshake and operand/product bus of mult_seq_signed.
// Ovf exists only when MULT_OVF_EN is defined.
interface mult_seq_signed_if #(
  parameter int WIDTH = 8
);
  logic               Run;
  logic [WIDTH-1:0]   Mcand;
  logic [WIDTH-1:0]   Mplier;
  logic [2*WIDTH-1:0] Product;
  logic               X;
  logic               Busy;
  logic               Done;
`ifdef MULT_OVF_EN
  logic               Ovf;

  modport master (output Run, Mcand, Mplier, input Product, X, Busy, Done, Ovf);
  modport slave  (input Run, Mcand, Mplier, output Product, X, Busy, Done, Ovf);
`else
  modport master (output Run, Mcand, Mplier, input Product, X, Busy, Done);
  modport slave  (input Run, Mcand, Mplier, output Product, X, Busy, Done);
`endif
endinterface

// File: rtl/add_sub_nbit.sv
// N-bit ripple add/subtract: S = A + B, or A - B when Sub is high
// (B inverted, carry-in = Sub).
module add_sub_nbit #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Sub,
  output logic [N-1:0] S,
  output logic         Cout
);
  logic [N:0]   c;
  logic [N-1:0] bx;

  assign c[0] = Sub;
  assign bx   = B ^ {N{Sub}};

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a   (A[i]),
      .b   (bx[i]),
      .cin (c[i]),
      .s   (S[i]),
      .cout(c[i+1])
    );
  end

  assign Cout = c[N];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the ripple cell of add_sub_nbit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mult_seq_signed.sv
// Sequential signed add-shift multiplier, one partial product per clock.
// Optional MULT_OVF_EN adds a registered Ovf flag on entry to DONE.
module mult_seq_signed
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  mult_seq_signed_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  mult_state_t      state_q;
  logic             x_q, busy_q, done_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0]    cnt_q;

  logic             last;
  logic [WIDTH:0]   sum, xa_d;
  logic             cout_unused;
  logic             x_d;
  logic [WIDTH-1:0] a_d, b_d;

  // Last step weights the multiplier sign bit negatively, hence the subtract.
  add_sub_nbit #(.N(WIDTH + 1)) u_addsub (
    .A   ({a_q[WIDTH-1], a_q}),
    .B   ({s_q[WIDTH-1], s_q}),
    .Sub (last),
    .S   (sum),
    .Cout(cout_unused)
  );

  always_comb begin
    last = (cnt_q == CW'(WIDTH - 1));
    xa_d = b_q[0] ? sum : {x_q, a_q};
    x_d  = xa_d[WIDTH];
    a_d  = {xa_d[WIDTH], xa_d[WIDTH-1:1]};
    b_d  = {xa_d[0], b_q[WIDTH-1:1]};
  end

`ifdef MULT_OVF_EN
  logic           ovf_q, ovf_d;
  logic [WIDTH:0] top_d;

  // Representable in WIDTH signed bits iff Product[2W-1:W-1] is all one value.
  always_comb begin
    top_d = {a_d, b_d[WIDTH-1]};
    ovf_d = !((top_d == '0) || (top_d == '1));
  end

  assign bus.Ovf = ovf_q;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.Run) begin
          state_q <= CALC;
          x_q     <= 1'b0;
          a_q     <= '0;
          b_q     <= bus.Mplier;
          s_q     <= bus.Mcand;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
`ifdef MULT_OVF_EN
          ovf_q   <= 1'b0;
`endif
        end
        CALC: begin
          x_q   <= x_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef MULT_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        DONE: if (!bus.Run) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Product = {a_q, b_q};
  assign bus.X       = x_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
endmodule

// File: tb/tb_mult_seq_signed.sv
// Self-checking bench for mult_seq_signed: 8-bit table plus 4-bit corner cases,
// scoreboard queues popped on each Done rise. Ovf checked when MULT_OVF_EN is defined.
module tb_mult_seq_signed;
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mult_seq_signed_if #(.WIDTH(8)) if8 ();
  mult_seq_signed_if #(.WIDTH(4)) if4 ();

  mult_seq_signed #(.WIDTH(8)) u8 (.Clk(Clk), .Reset(Reset), .bus(if8));
  mult_seq_signed #(.WIDTH(4)) u4 (.Clk(Clk), .Reset(Reset), .bus(if4));

  typedef struct { logic [7:0] mc; logic [7:0] mp; logic [15:0] prod; logic ovf; } vec8_t;
  typedef struct { logic [15:0] prod; logic ovf; int t0; } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic ovf8(input logic [15:0] p);
    logic [8:0] t;
    t = p[15:7];
    return !((t == 9'h000) || (t == 9'h1FF));
  endfunction

  // Monitor for the 8-bit instance
  initial begin : mon8
    exp_t e;
    int   busy = 0;
    logic dprev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) busy = 0;
      else begin
        if (if8.Busy) busy++;
        if (if8.Done && !dprev) begin
          chk("sb8_pending", 32'(q8.size() != 0), 32'd1);
          if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("prod8", 32'(if8.Product), 32'(e.prod));
`ifdef MULT_OVF_EN
            chk("ovf8", 32'(if8.Ovf), 32'(e.ovf));
`endif
            chk("latency8", 32'(cyc - e.t0), 32'd8);
            chk("busycnt8", 32'(busy), 32'd8);
            chk("busy_done8", 32'(if8.Busy), 32'd0);
          end
          busy = 0;
        end
      end
      dprev = if8.Done;
    end
  end

  // Monitor for the 4-bit instance
  initial begin : mon4
    exp_t e;
    int   busy = 0;
    logic dprev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) busy = 0;
      else begin
        if (if4.Busy) busy++;
        if (if4.Done && !dprev) begin
          chk("sb4_pending", 32'(q4.size() != 0), 32'd1);
          if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("prod4", 32'(if4.Product), 32'(e.prod[7:0]));
`ifdef MULT_OVF_EN
            chk("ovf4", 32'(if4.Ovf), 32'(e.ovf));
`endif
            chk("latency4", 32'(cyc - e.t0), 32'd4);
            chk("busycnt4", 32'(busy), 32'd4);
          end
          busy = 0;
        end
      end
      dprev = if4.Done;
    end
  end

  task automatic start8(input logic [7:0] mc, input logic [7:0] mp,
                        input logic [15:0] prod, input logic ovf);
    exp_t e;
    @(negedge Clk);
    if8.Run = 1'b1; if8.Mcand = mc; if8.Mplier = mp;
    @(posedge Clk); #1;
    e.prod = prod; e.ovf = ovf; e.t0 = cyc;
    q8.push_back(e);
  endtask

  task automatic start4(input logic [3:0] mc, input logic [3:0] mp,
                        input logic [7:0] prod, input logic ovf);
    exp_t e;
    @(negedge Clk);
    if4.Run = 1'b1; if4.Mcand = mc; if4.Mplier = mp;
    @(posedge Clk); #1;
    e.prod = {8'h00, prod}; e.ovf = ovf; e.t0 = cyc;
    q4.push_back(e);
  endtask

  // Drop Run and scramble operands; they must be ignored outside the start edge.
  task automatic release_run(input bit wide);
    @(negedge Clk);
    if (wide) begin
      if8.Run = 1'b0; if8.Mcand = 8'($urandom); if8.Mplier = 8'($urandom);
    end else begin
      if4.Run = 1'b0; if4.Mcand = 4'($urandom); if4.Mplier = 4'($urandom);
    end
  endtask

  task automatic wait_done(input bit wide);
    int k = 0;
    while (!(wide ? if8.Done : if4.Done) && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk(wide ? "done8_seen" : "done4_seen", 32'(wide ? if8.Done : if4.Done), 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    vec8_t tbl[$];
    vec8_t v;
    int    a, b, p;

    if8.Run = 1'b0; if8.Mcand = '0; if8.Mplier = '0;
    if4.Run = 1'b0; if4.Mcand = '0; if4.Mplier = '0;

    tbl.push_back('{8'h07, 8'hFD, 16'hFFEB, 1'b0});
    tbl.push_back('{8'h80, 8'h80, 16'h4000, 1'b1});
    tbl.push_back('{8'h05, 8'h05, 16'h0019, 1'b0});
    tbl.push_back('{8'h10, 8'h10, 16'h0100, 1'b1});
    tbl.push_back('{8'h00, 8'hFF, 16'h0000, 1'b0});
    tbl.push_back('{8'h7F, 8'h80, 16'hC080, 1'b1});
    tbl.push_back('{8'h80, 8'h01, 16'hFF80, 1'b0});
    tbl.push_back('{8'hFF, 8'hFF, 16'h0001, 1'b0});
    tbl.push_back('{8'h7F, 8'h7F, 16'h3F01, 1'b1});
    tbl.push_back('{8'h0B, 8'hF6, 16'hFF92, 1'b0});
    for (int i = 0; i < 8; i++) begin
      v.mc = 8'($urandom);
      v.mp = 8'($urandom);
      a = int'($signed(v.mc));
      b = int'($signed(v.mp));
      p = a * b;
      v.prod = p[15:0];
      v.ovf  = ovf8(v.prod);
      tbl.push_back(v);
    end

    repeat (3) @(negedge Clk);
    chk("rst_prod8", 32'(if8.Product), 32'd0);
    chk("rst_busy8", 32'(if8.Busy), 32'd0);
    chk("rst_done8", 32'(if8.Done), 32'd0);
    chk("rst_x8", 32'(if8.X), 32'd0);
    chk("rst_prod4", 32'(if4.Product), 32'd0);
`ifdef MULT_OVF_EN
    chk("rst_ovf8", 32'(if8.Ovf), 32'd0);
`endif
    Reset = 1'b0;

    foreach (tbl[i]) begin
      start8(tbl[i].mc, tbl[i].mp, tbl[i].prod, tbl[i].ovf);
      release_run(1'b1);
      wait_done(1'b1);
    end

    // Run held high: exactly one operation, then a 1-cycle low gap restarts.
    start8(8'd9, 8'hFE, 16'hFFEE, 1'b0);
    repeat (30) @(negedge Clk);
    chk("hold_done", 32'(if8.Done), 32'd1);
    chk("hold_busy", 32'(if8.Busy), 32'd0);
    chk("hold_prod", 32'(if8.Product), 32'hFFEE);
    if8.Run = 1'b0;
    start8(8'hFB, 8'd6, 16'hFFE2, 1'b0);
    release_run(1'b1);
    wait_done(1'b1);

    // Reset during the third CALC cycle abandons the operation.
    start8(8'd100, 8'hFD, 16'h0000, 1'b0);
    release_run(1'b1);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_busy", 32'(if8.Busy), 32'd0);
    chk("midrst_done", 32'(if8.Done), 32'd0);
    chk("midrst_prod", 32'(if8.Product), 32'd0);
    chk("midrst_x", 32'(if8.X), 32'd0);
    q8.delete();
    @(negedge Clk);
    Reset = 1'b0;
    start8(8'd3, 8'd4, 16'h000C, 1'b0);
    release_run(1'b1);
    wait_done(1'b1);

    // 4-bit instance corners
    start4(4'h8, 4'h8, 8'h40, 1'b1);
    release_run(1'b0);
    wait_done(1'b0);
    start4(4'h8, 4'h7, 8'hC8, 1'b1);
    release_run(1'b0);
    wait_done(1'b0);
    start4(4'h7, 4'h7, 8'h31, 1'b1);
    release_run(1'b0);
    wait_done(1'b0);
    start4(4'h3, 4'hE, 8'hFA, 1'b0);
    release_run(1'b0);
    wait_done(1'b0);

    repeat (3) @(negedge Clk);
    chk("sb8_empty", 32'(q8.size()), 32'd0);
    chk("sb4_empty", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
